// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI master controller: FSM state encoding and
// default parameter values.
package spi_ctrl_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_NO_OF_SLAVES = 1;
  localparam int DEF_BAUD_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    HOLD     = 2'd3
  } spi_ctrl_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// Baud/edge generator: half-period counter, sclk toggling, leading/trailing
// edge strobes and count of sclk edges produced in the current transfer.
module spi_sclk_gen
  import spi_ctrl_pkg::*;
#(
  parameter int BAUD_WIDTH = DEF_BAUD_WIDTH,
  parameter int EDGE_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  run,
  input  logic                  idle_level,
  input  logic [BAUD_WIDTH-1:0] baud_div,
  output logic                  sclk,
  output logic                  tick,
  output logic                  lead_stb,
  output logic                  trail_stb,
  output logic [EDGE_W-1:0]     edge_cnt
);

  logic [BAUD_WIDTH-1:0] hp_cnt;

  // tick marks the last clk cycle of a half-period; edges land on that edge.
  assign tick      = en && (hp_cnt == baud_div);
  assign lead_stb  = run && tick && !edge_cnt[0];
  assign trail_stb = run && tick && edge_cnt[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hp_cnt   <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
    end else begin
      if (!en || tick) hp_cnt <= '0;
      else             hp_cnt <= hp_cnt + BAUD_WIDTH'(1);

      if (!run)     edge_cnt <= '0;
      else if (tick) edge_cnt <= edge_cnt + EDGE_W'(1);

      // Outside a transfer sclk tracks the live cpol; once busy it is frozen
      // at the value captured on the accepting edge and only toggles.
      if (!en)              sclk <= idle_level;
      else if (run && tick) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: single-word transfers with selectable mode, bit order,
// chip select and baud divisor.
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NO_OF_SLAVES = DEF_NO_OF_SLAVES,
  parameter int BAUD_WIDTH   = DEF_BAUD_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          cpol,
  input  logic                          cpha,
  input  logic                          msb_first,
  input  logic [$clog2(NO_OF_SLAVES):0] slave_sel,
  input  logic [BAUD_WIDTH-1:0]         baud_div,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          sclk,
  output logic                          mosi,
  input  logic                          miso,
  output logic [NO_OF_SLAVES-1:0]       cs_n,
  output spi_ctrl_state_e               dbg_state
);

  // Handshake: start is taken only in a cycle where busy is low; a start
  // seen while busy is dropped. done (with err on a bad slave_sel) is a
  // one-cycle completion pulse, after which busy is low again.

  localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);

  spi_ctrl_state_e state_q, state_d;

  logic                    cpha_q, msb_q;
  logic [BAUD_WIDTH-1:0]   baud_q;
  logic [DATA_WIDTH-1:0]   tx_sh, rx_sh, rx_q;
  logic                    mosi_q, done_q, err_q;
  logic [NO_OF_SLAVES-1:0] cs_n_q;

  logic              tick, lead_stb, trail_stb;
  logic [EDGE_W-1:0] edge_cnt;
  logic              sel_ok, accept, reject, finish, last_edge;
  logic              shift_out, sample_in;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic msb);
    return msb ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w,
                                                       input logic msb);
    return msb ? (w << 1) : (w >> 1);
  endfunction

  assign sel_ok    = 32'(slave_sel) < NO_OF_SLAVES;
  assign last_edge = trail_stb && (edge_cnt == LAST_EDGE);

  // With cpha=1 the first leading edge re-drives bit 0 already placed in
  // SETUP, so the shifter is loaded unshifted in that mode.
  assign shift_out = cpha_q ? lead_stb : (trail_stb && !last_edge);
  assign sample_in = cpha_q ? trail_stb : lead_stb;

  spi_sclk_gen #(
    .BAUD_WIDTH (BAUD_WIDTH),
    .EDGE_W     (EDGE_W)
  ) u_sclk_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (state_q != IDLE),
    .run        (state_q == TRANSFER),
    .idle_level (cpol),
    .baud_div   (baud_q),
    .sclk       (sclk),
    .tick       (tick),
    .lead_stb   (lead_stb),
    .trail_stb  (trail_stb),
    .edge_cnt   (edge_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && sel_ok) begin
          accept  = 1'b1;
          state_d = SETUP;
        end else if (start) begin
          reject = 1'b1;
        end
      end
      SETUP:    if (tick) state_d = TRANSFER;
      TRANSFER: if (last_edge) state_d = HOLD;
      HOLD: begin
        if (tick) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpha_q <= 1'b0;
      msb_q  <= 1'b0;
      baud_q <= '0;
      tx_sh  <= '0;
      rx_sh  <= '0;
      rx_q   <= '0;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cs_n_q <= '1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        cpha_q <= cpha;
        msb_q  <= msb_first;
        baud_q <= baud_div;
        tx_sh  <= cpha ? tx_data : shift_word(tx_data, msb_first);
        mosi_q <= first_bit(tx_data, msb_first);
        cs_n_q <= ~(NO_OF_SLAVES'(1) << slave_sel);
        rx_sh  <= '0;
      end
      if (reject) begin
        done_q <= 1'b1;
        err_q  <= 1'b1;
      end
      if (shift_out) begin
        mosi_q <= first_bit(tx_sh, msb_q);
        tx_sh  <= shift_word(tx_sh, msb_q);
      end
      if (sample_in) begin
        if (msb_q) rx_sh <= {rx_sh[DATA_WIDTH-2:0], miso};
        else       rx_sh <= {miso, rx_sh[DATA_WIDTH-1:1]};
      end
      if (finish) begin
        cs_n_q <= '1;
        mosi_q <= 1'b0;
        rx_q   <= rx_sh;
        done_q <= 1'b1;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign mosi      = mosi_q;
  assign cs_n      = cs_n_q;
  assign rx_data   = rx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: an 8-bit/4-slave instance and a
// 32-bit/1-slave instance, checked against hand-computed values.
module tb_spi_master_ctrl;
  import spi_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- DUT a: 8 bit, 4 slaves ----------------
  logic            a_start = 1'b0, a_cpol = 1'b0, a_cpha = 1'b0, a_msb = 1'b1;
  logic [2:0]      a_sel = 3'd0;
  logic [7:0]      a_baud = 8'd0, a_tx = 8'd0, a_rx;
  logic            a_busy, a_done, a_err, a_sclk, a_mosi, a_miso;
  logic            a_loop = 1'b1, a_miso_fix = 1'b0;
  logic [3:0]      a_cs_n;
  spi_ctrl_state_e a_state;

  assign a_miso = a_loop ? a_mosi : a_miso_fix;

  spi_master_ctrl #(.DATA_WIDTH(8), .NO_OF_SLAVES(4), .BAUD_WIDTH(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .cpol(a_cpol), .cpha(a_cpha),
    .msb_first(a_msb), .slave_sel(a_sel), .baud_div(a_baud), .tx_data(a_tx),
    .rx_data(a_rx), .busy(a_busy), .done(a_done), .err(a_err), .sclk(a_sclk),
    .mosi(a_mosi), .miso(a_miso), .cs_n(a_cs_n), .dbg_state(a_state)
  );

  // ---------------- DUT b: 32 bit, 1 slave ----------------
  logic            b_start = 1'b0;
  logic [0:0]      b_sel = 1'b0;
  logic [7:0]      b_baud = 8'd0;
  logic [31:0]     b_tx = 32'd0, b_rx;
  logic            b_busy, b_done, b_err, b_sclk, b_mosi;
  logic [0:0]      b_cs_n;
  spi_ctrl_state_e b_state;

  spi_master_ctrl #(.DATA_WIDTH(32), .NO_OF_SLAVES(1), .BAUD_WIDTH(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .cpol(1'b0), .cpha(1'b0),
    .msb_first(1'b1), .slave_sel(b_sel), .baud_div(b_baud), .tx_data(b_tx),
    .rx_data(b_rx), .busy(b_busy), .done(b_done), .err(b_err), .sclk(b_sclk),
    .mosi(b_mosi), .miso(b_mosi), .cs_n(b_cs_n), .dbg_state(b_state)
  );

  // ---------------- monitors / scoreboard ----------------
  logic [0:0] exp_q[$];
  logic       scb_en = 1'b0;
  int         a_edges = 0, a_dones = 0;
  logic       a_sclk_p = 1'b0, a_busy_p = 1'b0;
  int         cyc = 0, b_edges = 0, b_first = 0, b_last = 0;
  logic       b_sclk_p = 1'b0, b_busy_p = 1'b0;

  // mosi is checked at every rising sclk edge while the scoreboard is armed
  always @(negedge clk) begin
    if (a_done) a_dones++;
    if (a_busy && a_busy_p && a_sclk != a_sclk_p) begin
      a_edges++;
      if (scb_en && a_sclk)
        check("mosi_bit", a_mosi, (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx);
    end
    a_sclk_p = a_sclk;
    a_busy_p = a_busy;
  end

  always @(negedge clk) begin
    cyc++;
    if (b_busy && b_busy_p && b_sclk != b_sclk_p) begin
      if (b_edges == 0) b_first = cyc;
      b_last = cyc;
      b_edges++;
    end
    b_sclk_p = b_sclk;
    b_busy_p = b_busy;
  end

  // ---------------- driver ----------------
  task automatic run_a(input logic cpol, input logic cpha, input logic msb,
                       input logic [2:0] sel, input logic [7:0] baud, input logic [7:0] tx,
                       input int restart_at, input logic [3:0] exp_cs,
                       input logic [7:0] old_rx, output int lat);
    @(negedge clk);
    a_cpol = cpol; a_cpha = cpha; a_msb = msb; a_sel = sel;
    a_baud = baud; a_tx = tx; a_start = 1'b1;
    a_edges = 0;
    lat = 0;
    while (lat < 3000) begin
      @(negedge clk);
      lat++;
      a_start = (lat == restart_at);
      if (lat == restart_at) begin
        a_tx   = ~tx;
        a_cpol = ~cpol;
      end
      if (lat == 1) check("sclk_setup_level", a_sclk, cpol);
      if (lat == 3) begin
        check("cs_active", a_cs_n, exp_cs);
        check("busy_active", a_busy, 1'b1);
        check("rx_hold", a_rx, old_rx);
      end
      if (a_done) break;
    end
  endtask

  // ---------------- stimulus ----------------
  int lat, base;

  initial begin
    a_cpol = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", a_cs_n, 4'hF);
    check("rst_sclk", a_sclk, 1'b0);
    check("rst_mosi", a_mosi, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_done_err", {a_done, a_err}, 2'b00);
    check("rst_rx", a_rx, 8'h00);
    check("rst_state", a_state, IDLE);
    rst = 1'b1;

    // abort by reset at cycle 10 of a transfer
    @(negedge clk);
    a_cpol = 1'b0; a_cpha = 1'b0; a_msb = 1'b1; a_sel = 3'd0;
    a_baud = 8'd1; a_tx = 8'hC3; a_loop = 1'b1; a_start = 1'b1;
    base = a_dones;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      a_start = 1'b0;
    end
    check("abort_pre_sclk", a_sclk, 1'b1);
    rst = 1'b0;
    #1;
    check("abort_cs_n", a_cs_n, 4'hF);
    check("abort_sclk", a_sclk, 1'b0);
    check("abort_busy", a_busy, 1'b0);
    check("abort_state", a_state, IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_done", a_dones - base, 0);
    check("abort_rx", a_rx, 8'h00);

    // mode 0, MSB first, loopback, baud_div 1
    a_loop = 1'b1;
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    scb_en = 1'b1;
    run_a(1'b0, 1'b0, 1'b1, 3'd0, 8'd1, 8'hA5, -1, 4'b1110, 8'h00, lat);
    scb_en = 1'b0;
    check("m0_latency", lat, 37);
    check("m0_rx", a_rx, 8'hA5);
    check("m0_edges", a_edges, 16);
    check("m0_bits_left", exp_q.size(), 0);
    check("m0_done_status", {a_busy, a_err, a_cs_n}, {1'b0, 1'b0, 4'hF});
    @(negedge clk);
    check("m0_done_single", a_done, 1'b0);
    check("m0_mosi_idle", a_mosi, 1'b0);

    // mode 3, LSB first, miso tied high, baud_div 2
    a_loop = 1'b0; a_miso_fix = 1'b1; a_cpol = 1'b1;
    repeat (2) @(negedge clk);
    check("m3_idle_high", a_sclk, 1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    scb_en = 1'b1;
    run_a(1'b1, 1'b1, 1'b0, 3'd1, 8'd2, 8'h3C, -1, 4'b1101, 8'hA5, lat);
    scb_en = 1'b0;
    check("m3_latency", lat, 55);
    check("m3_rx", a_rx, 8'hFF);
    check("m3_edges", a_edges, 16);
    check("m3_bits_left", exp_q.size(), 0);
    @(negedge clk);
    check("m3_sclk_after", a_sclk, 1'b1);

    // slave 2 of 4, baud_div 0
    a_loop = 1'b1;
    run_a(1'b0, 1'b0, 1'b1, 3'd2, 8'd0, 8'h5A, -1, 4'b1011, 8'hFF, lat);
    check("sel2_latency", lat, 19);
    check("sel2_rx", a_rx, 8'h5A);
    check("sel2_edges", a_edges, 16);

    // out-of-range slave select
    @(negedge clk);
    a_sel = 3'd5; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("bad_sel_err_done", {a_err, a_done}, 2'b11);
    check("bad_sel_cs_n", a_cs_n, 4'hF);
    check("bad_sel_busy", a_busy, 1'b0);
    @(negedge clk);
    check("bad_sel_pulse_end", {a_err, a_done}, 2'b00);
    repeat (5) @(negedge clk);
    check("bad_sel_state", a_state, IDLE);
    check("bad_sel_sclk", a_sclk, 1'b0);
    check("bad_sel_rx", a_rx, 8'h5A);

    // second start at cycle 5 is ignored; mode 1, loopback
    base = a_dones;
    run_a(1'b0, 1'b1, 1'b1, 3'd3, 8'd1, 8'h81, 5, 4'b0111, 8'h5A, lat);
    check("restart_latency", lat, 37);
    check("restart_rx", a_rx, 8'h81);
    check("restart_edges", a_edges, 16);
    repeat (50) @(negedge clk);
    check("restart_one_done", a_dones - base, 1);
    check("restart_busy", a_busy, 1'b0);
    check("restart_rx_kept", a_rx, 8'h81);

    // 32-bit word, baud_div 0, loopback
    @(negedge clk);
    b_tx = 32'hDEADBEEF; b_baud = 8'd0; b_sel = 1'b0; b_start = 1'b1;
    b_edges = 0;
    lat = 0;
    while (lat < 3000) begin
      @(negedge clk);
      lat++;
      b_start = 1'b0;
      if (lat == 3) check("w32_cs_active", b_cs_n, 1'b0);
      if (b_done) break;
    end
    check("w32_latency", lat, 67);
    check("w32_rx", b_rx, 32'hDEADBEEF);
    check("w32_edges", b_edges, 64);
    check("w32_edge_span", b_last - b_first, 63);
    check("w32_err", b_err, 1'b0);
    @(negedge clk);
    check("w32_cs_release", b_cs_n, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
